// File: rtl/kmeans_nearest_centroid.sv
// Nearest-centroid classifier: four 2-D centroids, one point per six cycles,
// squared Euclidean distance evaluated against one centroid per CALC cycle.
module kmeans_nearest_centroid (
    input  logic        clk,
    input  logic        reset,
    input  logic        cent_wr,
    input  logic [1:0]  cent_idx,
    input  logic [31:0] cent_data,
    input  logic        in_valid,
    input  logic [31:0] in_point,
    output logic        in_ready,
    output logic        out_valid,
    output logic [63:0] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] cent_r [4];
    logic [31:0] point_r;
    logic [1:0]  idx_r;
    logic [32:0] min_dist_r;
    logic [1:0]  min_idx_r;

    logic [32:0] dist_s;
    logic        take_s;
    logic [32:0] next_min_s;
    logic [1:0]  next_idx_s;

    // Squared distance between two packed {x,y} points, full 33-bit result.
    function automatic logic [32:0] sq_dist(input logic [31:0] p, input logic [31:0] c);
        logic [15:0] dx;
        logic [15:0] dy;
        logic [31:0] sx;
        logic [31:0] sy;
        dx = (p[31:16] >= c[31:16]) ? (p[31:16] - c[31:16]) : (c[31:16] - p[31:16]);
        dy = (p[15:0]  >= c[15:0])  ? (p[15:0]  - c[15:0])  : (c[15:0]  - p[15:0]);
        sx = {16'd0, dx} * {16'd0, dx};
        sy = {16'd0, dy} * {16'd0, dy};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

    // Distance to the current centroid and the running-minimum update.
    always_comb begin
        dist_s = sq_dist(point_r, cent_r[idx_r]);
        take_s = (idx_r == 2'd0) || (dist_s < min_dist_r);
        if (take_s) begin
            next_min_s = dist_s;
            next_idx_s = idx_r;
        end else begin
            next_min_s = min_dist_r;
            next_idx_s = min_idx_r;
        end
    end

    // Control FSM, centroid storage and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            for (int i = 0; i < 4; i++) begin
                cent_r[i] <= 32'd0;
            end
            point_r    <= 32'd0;
            idx_r      <= 2'd0;
            min_dist_r <= 33'd0;
            min_idx_r  <= 2'd0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= 64'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (cent_wr) begin
                        cent_r[cent_idx] <= cent_data;
                    end
                    if (in_valid) begin
                        point_r  <= in_point;
                        idx_r    <= 2'd0;
                        in_ready <= 1'b0;
                        state_r  <= CALC;
                    end
                end
                CALC: begin
                    min_dist_r <= next_min_s;
                    min_idx_r  <= next_idx_s;
                    idx_r      <= idx_r + 2'd1;
                    // The last comparison feeds the result word directly.
                    if (idx_r == 2'd3) begin
                        state_r   <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= {28'd0, next_idx_s, 1'b0, next_min_s};
                    end
                end
                DONE: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
